// File: rtl/prbs_pkg.sv
// prbs_pkg: constants and state type shared by the 4-bit PRBS generator and checker
package prbs_pkg;
    localparam logic [3:0] PRBS4_SEED   = 4'hF;
    localparam int         PRBS4_TAP0   = 0;
    localparam int         PRBS4_TAP1   = 1;
    localparam int         PRBS4_PERIOD = 15;
    typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;
endpackage

// File: rtl/prbs4_checker_if.sv
// prbs4_checker_if: serial bit stream in, lock/error status out
//   bit_in, bit_valid, err_clr : driven by the link side (master)
//   locked, err_pulse, err_count : driven by the checker (slave)
interface prbs4_checker_if #(parameter int ERR_CNT_W = 16);
    logic                 bit_in;
    logic                 bit_valid;
    logic                 err_clr;
    logic                 locked;
    logic                 err_pulse;
    logic [ERR_CNT_W-1:0] err_count;
    modport master (output bit_in, bit_valid, err_clr, input locked, err_pulse, err_count);
    modport slave  (input bit_in, bit_valid, err_clr, output locked, err_pulse, err_count);
endinterface

// File: rtl/prbs4_predictor.sv
// prbs4_predictor: 4-bit history with XOR tap predicting the next PRBS bit
//   clk, reset (async, active-low), shift: advance history,
//   use_pred: shift in the prediction instead of bit_in, pred: next expected bit,
//   hist: history, newest bit at [3], oldest at [0]
module prbs4_predictor
    import prbs_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       shift,
    input  logic       use_pred,
    input  logic       bit_in,
    output logic       pred,
    output logic [3:0] hist
);
    assign pred = hist[PRBS4_TAP0] ^ hist[PRBS4_TAP1];

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            hist <= '0;
        else if (shift)
            hist <= {use_pred ? pred : bit_in, hist[3:1]};
endmodule

// File: rtl/prbs4_checker.sv
// prbs4_checker: self-synchronising PRBS4 receiver with lock detection and error count
//   clk, reset (async, active-low)
//   bus.slave: bit_in/bit_valid/err_clr in; locked/err_pulse/err_count out (all registered)
module prbs4_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_COUNT = 8,
    parameter int LOSS_COUNT = 3,
    parameter int ERR_CNT_W  = 16
) (
    input logic              clk,
    input logic              reset,
    prbs4_checker_if.slave   bus
);
    localparam logic [7:0] LOCK_N = 8'(LOCK_COUNT);
    localparam logic [7:0] LOSS_N = 8'(LOSS_COUNT);

    state_t               state, state_n;
    logic [1:0]           fill, fill_n;
    logic [7:0]           match_cnt, match_n, miss_cnt, miss_n;
    logic                 locked, locked_n, err_pulse, err_pulse_n, err_inc;
    logic [ERR_CNT_W-1:0] err_count, err_count_n;
    logic                 pred, mismatch;
    logic [3:0]           hist;

    // Once locked the history free-runs on its own prediction so that a
    // single line error is counted once instead of corrupting later predictions.
    prbs4_predictor u_pred (
        .clk      (clk),
        .reset    (reset),
        .shift    (bus.bit_valid),
        .use_pred (state == LOCKED),
        .bit_in   (bus.bit_in),
        .pred     (pred),
        .hist     (hist)
    );

    assign mismatch = bus.bit_in ^ pred;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state     <= SEED;
            fill      <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_n;
            fill      <= fill_n;
            match_cnt <= match_n;
            miss_cnt  <= miss_n;
            locked    <= locked_n;
            err_pulse <= err_pulse_n;
            err_count <= err_count_n;
        end

    always_comb begin
        state_n = state;
        fill_n  = fill;
        match_n = match_cnt;
        miss_n  = miss_cnt;
        err_inc = 1'b0;
        if (bus.bit_valid)
            case (state)
                SEED: begin
                    fill_n = fill + 2'd1;
                    // An all-zero history is the PRBS lock-up state; keep seeding.
                    if (fill == 2'd3 && {bus.bit_in, hist[3:1]} != 4'd0) begin
                        state_n = VERIFY;
                        match_n = '0;
                    end
                end
                VERIFY: begin
                    match_n = match_cnt + 8'd1;
                    if (mismatch) begin
                        state_n = SEED;
                        fill_n  = '0;
                    end else if (match_n == LOCK_N) begin
                        state_n = LOCKED;
                        miss_n  = '0;
                    end
                end
                LOCKED: begin
                    err_inc = mismatch;
                    miss_n  = mismatch ? miss_cnt + 8'd1 : 8'd0;
                    if (mismatch && miss_n == LOSS_N) begin
                        state_n = SEED;
                        fill_n  = '0;
                    end
                end
                default: state_n = SEED;
            endcase
    end

    always_comb begin
        locked_n    = state_n == LOCKED;
        err_pulse_n = err_inc;
        err_count_n = bus.err_clr ? '0 : (err_inc && !(&err_count)) ? err_count + 1'b1 : err_count;
    end

    assign bus.locked    = locked;
    assign bus.err_pulse = err_pulse;
    assign bus.err_count = err_count;
endmodule

// File: tb/tb_prbs4_checker.sv
// tb_prbs4_checker: directed scoreboard bench for prbs4_checker (16-bit and 2-bit counters)
module tb_prbs4_checker;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    prbs4_checker_if #(.ERR_CNT_W(16)) bus1 ();
    prbs4_checker_if #(.ERR_CNT_W(2))  bus2 ();

    assign bus2.bit_in    = bus1.bit_in;
    assign bus2.bit_valid = bus1.bit_valid;
    assign bus2.err_clr   = bus1.err_clr;

    prbs4_checker #(.ERR_CNT_W(16)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    prbs4_checker #(.ERR_CNT_W(2))  dut2 (.clk(clk), .reset(reset), .bus(bus2));

    typedef struct {
        logic  lk;
        logic  pl;
        int    cnt;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   ncmp = 0;
    int   nerr = 0;
    int   pos  = 0;
    int   ecnt = 0;
    int   seq[15] = '{1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 0};

    function automatic logic gen(input int k);
        return seq[k % 15] != 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic b, input logic v, input logic c,
                        input logic el, input logic ep, input int ec, input string tag);
        exp_t e;
        bus1.bit_in    = b;
        bus1.bit_valid = v;
        bus1.err_clr   = c;
        sb.push_back('{el, ep, ec, tag});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, "_locked"}, 32'(bus1.locked), 32'(e.lk));
        chk({e.tag, "_pulse"}, 32'(bus1.err_pulse), 32'(e.pl));
        chk({e.tag, "_count"}, 32'(bus1.err_count), 32'(e.cnt));
        chk({e.tag, "_locked_w2"}, 32'(bus2.locked), 32'(e.lk));
        chk({e.tag, "_count_w2"}, 32'(bus2.err_count), 32'(e.cnt > 3 ? 3 : e.cnt));
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        bus1.bit_in = 1'b0;
        bus1.bit_valid = 1'b0;
        bus1.err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_locked"}, 32'(bus1.locked), 32'd0);
        chk({tag, "_pulse"}, 32'(bus1.err_pulse), 32'd0);
        chk({tag, "_count"}, 32'(bus1.err_count), 32'd0);
        reset = 1'b1;
        ecnt = 0;
    endtask

    initial begin
        do_reset("reset0");
        // clean stream from 1111: lock after the 12th valid bit, no errors
        pos = 0;
        for (int i = 1; i <= 60; i++) begin
            step(gen(pos), 1'b1, 1'b0, i >= 12, 1'b0, 0, "clean");
            pos++;
        end
        // single error while locked
        ecnt = 1;
        step(~gen(pos), 1'b1, 1'b0, 1'b1, 1'b1, ecnt, "single");
        pos++;
        for (int i = 0; i < 10; i++) begin
            step(gen(pos), 1'b1, 1'b0, 1'b1, 1'b0, ecnt, "after_single");
            pos++;
        end
        // err_clr on a clean bit
        ecnt = 0;
        step(gen(pos), 1'b1, 1'b1, 1'b1, 1'b0, ecnt, "clr");
        pos++;
        // three consecutive errors drop lock on the third
        for (int k = 1; k <= 3; k++) begin
            ecnt = k;
            step(~gen(pos), 1'b1, 1'b0, k < 3, 1'b1, ecnt, "loss");
            pos++;
        end
        for (int i = 1; i <= 12; i++) begin
            step(gen(pos), 1'b1, 1'b0, i >= 12, 1'b0, ecnt, "relock");
            pos++;
        end
        // err_clr wins over a simultaneous increment; pulse still fires
        ecnt = 0;
        step(~gen(pos), 1'b1, 1'b1, 1'b1, 1'b1, ecnt, "clr_err");
        pos++;
        step(gen(pos), 1'b1, 1'b0, 1'b1, 1'b0, ecnt, "clr_err_next");
        pos++;
        // five isolated errors: 16-bit reaches 5, 2-bit saturates at 3
        for (int k = 0; k < 5; k++) begin
            ecnt++;
            step(~gen(pos), 1'b1, 1'b0, 1'b1, 1'b1, ecnt, "sat_err");
            pos++;
            for (int j = 0; j < 2; j++) begin
                step(gen(pos), 1'b1, 1'b0, 1'b1, 1'b0, ecnt, "sat_gap");
                pos++;
            end
        end
        // asynchronous reset mid-lock, checked between clock edges
        #2;
        reset = 1'b0;
        #1;
        chk("async_locked", 32'(bus1.locked), 32'd0);
        chk("async_count", 32'(bus1.err_count), 32'd0);
        chk("async_count_w2", 32'(bus2.err_count), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        ecnt = 0;
        // arbitrary phase with bit_valid gaps 1,0,0
        pos = 7;
        begin
            int nv;
            nv = 0;
            for (int i = 0; i < 45; i++) begin
                logic v;
                v = (i % 3) == 0;
                if (v) nv++;
                step(v ? gen(pos) : 1'($urandom), v, 1'b0, nv >= 12, 1'b0, 0, "gap");
                if (v) pos++;
            end
        end
        // all-zero stream never locks
        do_reset("reset1");
        for (int i = 0; i < 40; i++)
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, "zeros");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
